// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM fader.
// Holds the per-channel state encoding and the default sizing constants
// used by led_pwm_fader and led_pwm_channel.
package led_pkg;

  // Channel state encoding. The values are fixed so that the low bit alone
  // tells a ramping state (RISE, FALL) from a settled one (OFF, ON).
  localparam logic [1:0] ST_OFF  = 2'b00;
  localparam logic [1:0] ST_RISE = 2'b01;
  localparam logic [1:0] ST_ON   = 2'b10;
  localparam logic [1:0] ST_FALL = 2'b11;

  // Default sizing.
  localparam int unsigned DEF_CH         = 4;
  localparam int unsigned DEF_PWM_BITS   = 8;
  localparam int unsigned DEF_STEP_DIV   = 16;
  localparam bit          DEF_ACTIVE_LOW = 1'b1;

endpackage : led_pkg

// File: rtl/led_pwm_channel.sv
// One LED channel: fade FSM, saturating duty ramp, duty shadow register
// and the PWM compare.
// Ports:
//   osc_clk       - oscillator clock
//   rst_i         - asynchronous active-high reset
//   led_in_i      - target level for this channel (1 = lit)
//   step_tick_i   - one-cycle ramp step strobe from the shared prescaler
//   pwm_cnt_i     - shared PWM counter
//   shadow_load_i - high on the last cycle of each PWM period
//   on_o          - raw compare result (before enable and polarity)
//   busy_o        - channel is in RISE or FALL
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = DEF_PWM_BITS
) (
  input  logic                osc_clk,
  input  logic                rst_i,
  input  logic                led_in_i,
  input  logic                step_tick_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                shadow_load_i,
  output logic                on_o,
  output logic                busy_o
);

  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

  logic [1:0]          state_q, state_d, dir_state;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] shadow_q, shadow_d;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    dir_state = state_q;
    duty_d    = duty_q;
    state_d   = state_q;
    shadow_d  = shadow_q;

    // Direction follows led_in first; a step_tick on the same cycle then
    // moves the duty in the new direction.
    case (state_q)
      ST_OFF:  if (led_in_i)  dir_state = ST_RISE;
      ST_RISE: if (!led_in_i) dir_state = ST_FALL;
      ST_ON:   if (!led_in_i) dir_state = ST_FALL;
      ST_FALL: if (led_in_i)  dir_state = ST_RISE;
      default: dir_state = ST_OFF;
    endcase

    // Saturating ramp: duty never wraps past 0 or MAX.
    if (step_tick_i) begin
      if (dir_state == ST_RISE && duty_q != MAX)
        duty_d = duty_q + ONE;
      else if (dir_state == ST_FALL && duty_q != '0)
        duty_d = duty_q - ONE;
    end

    // Settle once the ramp has reached its end point.
    state_d = dir_state;
    if (dir_state == ST_RISE && duty_d == MAX)
      state_d = ST_ON;
    else if (dir_state == ST_FALL && duty_d == '0)
      state_d = ST_OFF;

    // Duty is only sampled into the compare at a period boundary, so a
    // ramp step never changes the period currently being emitted.
    if (shadow_load_i)
      shadow_d = duty_q;
  end

  // NOTE: asynchronous reset in the sensitivity list, and non-blocking
  // assignments for all state so every register samples pre-edge values.
  always_ff @(posedge osc_clk or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_OFF;
      duty_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      shadow_q <= shadow_d;
    end
  end

  // Lit for the first shadow_q counts of each period; MAX is solid on.
  assign on_o   = (shadow_q == MAX) | (shadow_q > pwm_cnt_i);
  assign busy_o = (state_q == ST_RISE) | (state_q == ST_FALL);

endmodule : led_pwm_channel

// File: rtl/led_pwm_fader.sv
// LED PWM fader: takes a per-channel on/off pattern and drives each LED pin
// with PWM whose duty ramps up/down instead of switching hard.
// Ports:
//   osc_clk   - oscillator clock (single domain)
//   rst       - asynchronous active-high reset
//   led_in    - target pattern, 1 = channel lit
//   enable    - 0 forces pins dark and freezes ramps
//   led_out   - registered PWM drive to the pins, polarity per ACTIVE_LOW
//   ramp_busy - registered, 1 while any channel is ramping
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int unsigned CH         = DEF_CH,
  parameter int unsigned PWM_BITS   = DEF_PWM_BITS,
  parameter int unsigned STEP_DIV   = DEF_STEP_DIV,
  parameter bit          ACTIVE_LOW = DEF_ACTIVE_LOW
) (
  input  logic          osc_clk,
  input  logic          rst,
  input  logic [CH-1:0] led_in,
  input  logic          enable,
  output logic [CH-1:0] led_out,
  output logic          ramp_busy
);

  localparam logic [CH-1:0]       OFF_LEVEL = {CH{ACTIVE_LOW}};
  localparam logic [STEP_DIV-1:0] PRE_ONE   = STEP_DIV'(1);
  localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);

  logic [STEP_DIV-1:0] presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [CH-1:0]       led_out_q, led_out_d;
  logic                ramp_busy_q, ramp_busy_d;

  logic                step_tick;
  logic                shadow_load;
  logic [CH-1:0]       ch_on;
  logic [CH-1:0]       ch_busy;

  // Prescaler holds while disabled, so ramps resume exactly where they froze.
  assign step_tick   = enable & (presc_q == '1);
  assign shadow_load = (pwm_cnt_q == '1);

  always_comb begin
    presc_d     = enable ? presc_q + PRE_ONE : presc_q;
    pwm_cnt_d   = pwm_cnt_q + PWM_ONE;
    led_out_d   = (ch_on & {CH{enable}}) ^ OFF_LEVEL;
    ramp_busy_d = |ch_busy;
  end

  always_ff @(posedge osc_clk or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      pwm_cnt_q   <= '0;
      led_out_q   <= OFF_LEVEL;
      ramp_busy_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      pwm_cnt_q   <= pwm_cnt_d;
      led_out_q   <= led_out_d;
      ramp_busy_q <= ramp_busy_d;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .osc_clk       (osc_clk),
      .rst_i         (rst),
      .led_in_i      (led_in[i]),
      .step_tick_i   (step_tick),
      .pwm_cnt_i     (pwm_cnt_q),
      .shadow_load_i (shadow_load),
      .on_o          (ch_on[i]),
      .busy_o        (ch_busy[i])
    );
  end

  assign led_out   = led_out_q;
  assign ramp_busy = ramp_busy_q;

endmodule : led_pwm_fader

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader (CH=4, PWM_BITS=4, STEP_DIV=2,
// active-low pins). A behavioural model tracks each channel as an integer
// duty that moves one step toward its target on every ramp step, and
// predicts led_out / ramp_busy every clock.
module tb_led_pwm_fader;

  localparam int CH       = 4;
  localparam int PWM_BITS = 4;
  localparam int STEP_DIV = 2;
  localparam int MAXV     = (1 << PWM_BITS) - 1;
  localparam int DIVN     = 1 << STEP_DIV;

  logic          osc_clk;
  logic          rst;
  logic [CH-1:0] led_in;
  logic          enable;
  logic [CH-1:0] led_out;
  logic          ramp_busy;

  led_pwm_fader #(
    .CH         (CH),
    .PWM_BITS   (PWM_BITS),
    .STEP_DIV   (STEP_DIV),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .osc_clk   (osc_clk),
    .rst       (rst),
    .led_in    (led_in),
    .enable    (enable),
    .led_out   (led_out),
    .ramp_busy (ramp_busy)
  );

  initial osc_clk = 1'b0;
  always #5 osc_clk = ~osc_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int          m_duty   [CH];
  int          m_shadow [CH];
  bit          m_ramping[CH];   // channel not yet at its target after last edge
  int          m_presc;
  int          m_pwm;
  logic [CH-1:0] exp_led;
  logic          exp_busy;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_duty[i] = 0; m_shadow[i] = 0; m_ramping[i] = 1'b0;
    end
    m_presc  = 0;
    m_pwm    = 0;
    exp_led  = '1;
    exp_busy = 1'b0;
  endtask

  // One clock edge, using the inputs that were stable before the edge.
  task automatic model_step();
    bit tick;
    bit any_ramp;
    int target;
    tick     = enable && (m_presc == DIVN - 1);
    any_ramp = 1'b0;
    for (int i = 0; i < CH; i++) begin
      // Pin is lit (driven low) for the first 'shadow' counts of a period,
      // or all the time at full duty, and only while enabled.
      exp_led[i] = !(enable && (m_shadow[i] == MAXV || m_pwm < m_shadow[i]));
      any_ramp   = any_ramp | m_ramping[i];
    end
    exp_busy = any_ramp;
    for (int i = 0; i < CH; i++) begin
      target = led_in[i] ? MAXV : 0;
      if (m_pwm == MAXV) m_shadow[i] = m_duty[i];
      if (tick) begin
        if (m_duty[i] < target) m_duty[i]++;
        else if (m_duty[i] > target) m_duty[i]--;
      end
      m_ramping[i] = (m_duty[i] != target);
    end
    if (enable) m_presc = (m_presc + 1) % DIVN;
    m_pwm = (m_pwm + 1) % (MAXV + 1);
  endtask

  // Advance one clock, update the model, compare shortly after the edge.
  task automatic step_cycle();
    @(posedge osc_clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    check("led_out",   32'(led_out),   32'(exp_led));
    check("ramp_busy", 32'(ramp_busy), 32'(exp_busy));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step_cycle();
  endtask

  initial begin
    rst    = 1'b1;
    led_in = '0;
    enable = 1'b1;
    model_reset();
    run(3);
    rst = 1'b0;

    // Full rise of channel 0: 15 steps of 4 cycles, then solid on.
    led_in = 4'b0001;
    run(80);
    check("rise_busy_done", 32'(ramp_busy), 32'd0);
    check("rise_solid_on",  32'(led_out),   32'h0000000e);
    run(32);

    // Fall back to dark.
    led_in = 4'b0000;
    run(70);
    check("fall_busy_done", 32'(ramp_busy), 32'd0);
    check("fall_dark",      32'(led_out),   32'h0000000f);

    // Partial rise, reversal mid-ramp, then rise again.
    led_in = 4'b0001;
    run(26);
    led_in = 4'b0000;
    run(12);
    led_in = 4'b0001;
    run(20);

    // Freeze: pins dark on the next edge, ramp held for 1000 cycles.
    enable = 1'b0;
    step_cycle();
    check("enable_off_dark", 32'(led_out), 32'h0000000f);
    run(1000);
    enable = 1'b1;
    run(100);

    // Asynchronous reset mid-ramp, between clock edges.
    led_in = 4'b1111;
    run(20);
    #2 rst = 1'b1;
    #1;
    check("async_rst_led",  32'(led_out),   32'h0000000f);
    check("async_rst_busy", 32'(ramp_busy), 32'd0);
    model_reset();
    run(3);
    rst = 1'b0;
    run(40);

    // Randomized stretch: occasional pattern changes and enable drops.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 39) == 0) led_in = CH'($urandom);
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      step_cycle();
    end
    enable = 1'b1;
    run(50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_led_pwm_fader
